// File: rtl/pattern_player_ctrl.sv
// ---------------------------------------------------------------------------
// pattern_player_ctrl
//
// Plays LED patterns stored in the pattern memory. The current sequence
// number and step index form the read address. Each fetched word supplies a
// 10-bit pattern, a hold time counted in throttle ticks, and an
// end-of-sequence flag. The debounced up/down buttons select the sequence,
// and run pauses or resumes playback. Everything runs in the clk_50 domain.
//
// Ports
//   clk_50       in   system clock
//   reset        in   synchronous reset, active-low
//   tick         in   1-cycle step-pacing strobe
//   pb_seq_up    in   debounced level; a rising edge selects the next sequence
//   pb_seq_dn    in   debounced level; a rising edge selects the previous one
//   run          in   1 = play, 0 = pause
//   mem_q        in   memory read data
//   mem_rd       out  read strobe, one cycle per fetch
//   mem_addr     out  {seq_num, step}, registered
//   pattern      out  current LED pattern
//   pattern_stb  out  1-cycle pulse when pattern updates
//   seq_num      out  current sequence
//   step         out  current step
// ---------------------------------------------------------------------------
module pattern_player_ctrl #(
    parameter int SEQ_W  = 6,
    parameter int STEP_W = 4,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic                    clk_50,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    pb_seq_up,
    input  logic                    pb_seq_dn,
    input  logic                    run,
    input  logic [DATA_W-1:0]       mem_q,
    output logic                    mem_rd,
    output logic [SEQ_W+STEP_W-1:0] mem_addr,
    output logic [9:0]              pattern,
    output logic                    pattern_stb,
    output logic [SEQ_W-1:0]        seq_num,
    output logic [STEP_W-1:0]       step
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [1:0] LAT = RD_LAT[1:0];

    logic [1:0]              state_q, state_d;
    logic [SEQ_W-1:0]        seq_q, seq_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic [9:0]              pattern_q, pattern_d;
    logic                    stb_q, stb_d;
    logic [SEQ_W+STEP_W-1:0] addr_q, addr_d;
    logic [3:0]              hold_q, hold_d;
    logic                    eos_q, eos_d;
    logic [1:0]              lat_q, lat_d;
    logic                    up_q, dn_q;

    logic up_edge, dn_edge, seq_chg;

    // Bit 14 and any bits above 15 carry no meaning for playback.
    logic unused_mem_bits;
    assign unused_mem_bits = ^{mem_q[14], mem_q[DATA_W-1:15]};

    assign up_edge = pb_seq_up & ~up_q;
    assign dn_edge = pb_seq_dn & ~dn_q;
    // Simultaneous up and down edges cancel out.
    assign seq_chg = up_edge ^ dn_edge;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        seq_d     = seq_q;
        step_d    = step_q;
        pattern_d = pattern_q;
        stb_d     = 1'b0;
        addr_d    = addr_q;
        hold_d    = hold_q;
        eos_d     = eos_q;
        lat_d     = lat_q;

        if (seq_chg) begin
            // A sequence change overrides a same-cycle tick or data capture;
            // an outstanding read is simply never captured.
            seq_d   = up_edge ? seq_q + 1'b1 : seq_q - 1'b1;
            step_d  = '0;
            state_d = run ? S_FETCH : S_IDLE;
        end else if (!run) begin
            // Pausing abandons any read; resuming refetches the current step.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_FETCH;
                S_FETCH: begin
                    state_d = S_WAIT;
                    lat_d   = 2'd1;
                end
                S_WAIT: begin
                    if (lat_q == LAT) begin
                        pattern_d = mem_q[9:0];
                        hold_d    = (mem_q[13:10] == 4'd0) ? 4'd1 : mem_q[13:10];
                        eos_d     = mem_q[15];
                        stb_d     = 1'b1;
                        state_d   = S_HOLD;
                    end else begin
                        lat_d = lat_q + 2'd1;
                    end
                end
                S_HOLD: begin
                    if (tick) begin
                        if (hold_q <= 4'd1) begin
                            step_d  = (eos_q || step_q == '1) ? '0 : step_q + 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            hold_d = hold_q - 4'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // The address is latched on entry to FETCH and stays put through WAIT.
        if (state_d == S_FETCH) begin
            addr_d = {seq_d, step_d};
        end
    end

    // NOTE: reset is sampled only on the clock edge, so it does not appear in
    // the sensitivity list; state updates use non-blocking assignments so all
    // registers see the values from before the edge.
    always_ff @(posedge clk_50) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            seq_q     <= '0;
            step_q    <= '0;
            pattern_q <= '0;
            stb_q     <= 1'b0;
            addr_q    <= '0;
            hold_q    <= '0;
            eos_q     <= 1'b0;
            lat_q     <= '0;
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            seq_q     <= seq_d;
            step_q    <= step_d;
            pattern_q <= pattern_d;
            stb_q     <= stb_d;
            addr_q    <= addr_d;
            hold_q    <= hold_d;
            eos_q     <= eos_d;
            lat_q     <= lat_d;
            up_q      <= pb_seq_up;
            dn_q      <= pb_seq_dn;
        end
    end

    assign mem_rd      = (state_q == S_FETCH);
    assign mem_addr    = addr_q;
    assign pattern     = pattern_q;
    assign pattern_stb = stb_q;
    assign seq_num     = seq_q;
    assign step        = step_q;

endmodule

// File: tb/tb_pattern_player_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pattern_player_ctrl
//
// Drives pattern_player_ctrl against a small behavioural pattern memory.
// Each expected pattern update (address, pattern) is queued when the
// stimulus that causes it is applied. A monitor pops one entry per
// pattern_stb and compares the pattern, the address, and the read-to-strobe
// latency.
// ---------------------------------------------------------------------------
module tb_pattern_player_ctrl;

    localparam int SEQ_W  = 6;
    localparam int STEP_W = 4;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 1;
    localparam int AW     = SEQ_W + STEP_W;

    logic              clk_50 = 1'b0;
    logic              reset;
    logic              tick;
    logic              pb_seq_up;
    logic              pb_seq_dn;
    logic              run;
    logic [DATA_W-1:0] mem_q;
    logic              mem_rd;
    logic [AW-1:0]     mem_addr;
    logic [9:0]        pattern;
    logic              pattern_stb;
    logic [SEQ_W-1:0]  seq_num;
    logic [STEP_W-1:0] step;

    pattern_player_ctrl #(
        .SEQ_W (SEQ_W),
        .STEP_W(STEP_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk_50     (clk_50),
        .reset      (reset),
        .tick       (tick),
        .pb_seq_up  (pb_seq_up),
        .pb_seq_dn  (pb_seq_dn),
        .run        (run),
        .mem_q      (mem_q),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .pattern    (pattern),
        .pattern_stb(pattern_stb),
        .seq_num    (seq_num),
        .step       (step)
    );

    always #5 clk_50 = ~clk_50;

    // Memory model for RD_LAT=1. Data is valid only in the cycle after the
    // strobe; otherwise a filler word is returned, so a capture at the wrong
    // time shows up as pattern 0x3FF.
    logic [DATA_W-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk_50) begin
        mem_q <= mem_rd ? mem[mem_addr] : 16'h03FF;
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [9:0]    pat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errs   = 0;
    int   cyc      = 0;
    int   last_rd  = 0;
    int   stb_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input int a);
        exp_t e;
        e.addr = AW'(a);
        e.pat  = mem[a][9:0];
        sb.push_back(e);
    endtask

    // Monitor: one scoreboard entry is consumed per pattern strobe.
    always @(negedge clk_50) begin
        cyc++;
        if (mem_rd === 1'b1) last_rd = cyc;
        if (pattern_stb === 1'b1) begin
            stb_cnt++;
            if (sb.size() == 0) begin
                check("stb_unexpected", 32'(pattern), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_pattern", 32'(pattern), 32'(e.pat));
                check("sb_addr", 32'(mem_addr), 32'(e.addr));
                check("sb_latency", 32'(cyc - last_rd), 32'(RD_LAT + 1));
            end
        end
    end

    task automatic wait_stb(input int budget);
        int start;
        bit seen;
        start = stb_cnt;
        seen  = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk_50);
            #1;
            if (stb_cnt != start) seen = 1'b1;
        end
        if (!seen) check("stb_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_tick();
        @(posedge clk_50);
        #1 tick = 1'b1;
        @(posedge clk_50);
        #1 tick = 1'b0;
    endtask

    task automatic set_btn(input logic up, input logic dn);
        @(posedge clk_50);
        #1;
        pb_seq_up = up;
        pb_seq_dn = dn;
        @(posedge clk_50);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Default words: hold 1, no EOS, address-derived pattern.
        for (int a = 0; a < (1 << AW); a++) begin
            mem[a] = 16'h0400 | 16'((a * 37 + 5) % 1024);
        end
        mem[10'h000] = 16'h0955;   // pattern 0x155, hold 2
        mem[10'h002] = 16'h00AA;   // hold 0, treated as 1
        mem[10'h003] = 16'h8401;   // EOS, hold 1
        mem[10'h020] = 16'h1400 | 16'h0123;   // hold 5
        mem[10'h021] = 16'h1400 | 16'h0321;   // hold 5

        reset = 1'b0; run = 1'b1; tick = 1'b0;
        pb_seq_up = 1'b0; pb_seq_dn = 1'b0;

        // Reset held low for three cycles with run=1.
        repeat (3) begin
            @(negedge clk_50);
            check("rst_rd", 32'(mem_rd), 32'd0);
            check("rst_addr", 32'(mem_addr), 32'd0);
            check("rst_pattern", 32'(pattern), 32'd0);
            check("rst_stb", 32'(pattern_stb), 32'd0);
            check("rst_seq", 32'(seq_num), 32'd0);
            check("rst_step", 32'(step), 32'd0);
        end

        // First fetch: mem_rd in cycle 1, strobe in cycle 3.
        push_exp(10'h000);
        @(posedge clk_50);
        #1 reset = 1'b1;
        @(negedge clk_50); check("c0_rd", 32'(mem_rd), 32'd0);
        @(negedge clk_50); check("c1_rd", 32'(mem_rd), 32'd1);
                           check("c1_addr", 32'(mem_addr), 32'h000);
        @(negedge clk_50); check("c2_stb", 32'(pattern_stb), 32'd0);
        @(negedge clk_50); check("c3_stb", 32'(pattern_stb), 32'd1);
                           check("c3_pattern", 32'(pattern), 32'h155);

        // Hold of 2: the first tick does not advance, the second does.
        do_tick();
        @(negedge clk_50); check("hold2_t1_rd", 32'(mem_rd), 32'd0);
        push_exp(10'h001);
        do_tick();
        @(negedge clk_50); check("hold2_t2_rd", 32'(mem_rd), 32'd1);
                           check("hold2_t2_addr", 32'(mem_addr), 32'h001);
        wait_stb(20);

        // Steps 2 (hold 0 -> 1) and 3.
        for (int s = 2; s <= 3; s++) begin
            push_exp(s);
            do_tick();
            @(negedge clk_50); check("step_addr", 32'(mem_addr), 32'(s));
            wait_stb(20);
        end

        // Step 3 carries EOS: wrap to step 0.
        push_exp(10'h000);
        do_tick();
        @(negedge clk_50); check("eos_step", 32'(step), 32'd0);
                           check("eos_addr", 32'(mem_addr), 32'h000);
        wait_stb(20);

        // Down at sequence 0 wraps to 63; a held level changes only once.
        push_exp(10'h3F0);
        set_btn(1'b0, 1'b1);
        @(negedge clk_50); check("dn_seq", 32'(seq_num), 32'd63);
                           check("dn_addr", 32'(mem_addr), 32'h3F0);
        wait_stb(20);
        repeat (5) @(negedge clk_50);
        check("dn_level_seq", 32'(seq_num), 32'd63);
        set_btn(1'b0, 1'b0);

        // Up at 63 wraps to 0.
        push_exp(10'h000);
        set_btn(1'b1, 1'b0);
        @(negedge clk_50); check("up_wrap_seq", 32'(seq_num), 32'd0);
        wait_stb(20);
        set_btn(1'b0, 1'b0);

        // Both buttons rise together: no change, no fetch.
        set_btn(1'b1, 1'b1);
        @(negedge clk_50); check("both_seq", 32'(seq_num), 32'd0);
                           check("both_rd", 32'(mem_rd), 32'd0);
        set_btn(1'b0, 1'b0);

        // Up during WAIT: the read for step 1 is discarded, {1,0} is fetched.
        do_tick();
        do_tick();                       // now in FETCH for 0x001
        @(posedge clk_50);
        #1;                              // WAIT cycle
        push_exp(10'h010);
        pb_seq_up = 1'b1;
        @(posedge clk_50);
        @(negedge clk_50);
        check("upwait_pattern", 32'(pattern), 32'h155);
        check("upwait_stb", 32'(pattern_stb), 32'd0);
        check("upwait_seq", 32'(seq_num), 32'd1);
        check("upwait_addr", 32'(mem_addr), 32'h010);
        check("upwait_rd", 32'(mem_rd), 32'd1);
        wait_stb(20);
        set_btn(1'b0, 1'b0);

        // Tick during WAIT is dropped: hold 5 still needs five ticks.
        push_exp(10'h020);
        @(posedge clk_50);
        #1 pb_seq_up = 1'b1;             // edge seen at end of this cycle
        @(posedge clk_50);
        #1;                              // FETCH
        @(posedge clk_50);
        #1 tick = 1'b1;                  // WAIT
        @(posedge clk_50);
        #1 tick = 1'b0; pb_seq_up = 1'b0;
        @(negedge clk_50); check("waittick_stb", 32'(pattern_stb), 32'd1);
        for (int k = 0; k < 4; k++) begin
            do_tick();
            @(negedge clk_50); check("hold5_rd", 32'(mem_rd), 32'd0);
        end
        push_exp(10'h021);
        do_tick();
        @(negedge clk_50); check("hold5_last_rd", 32'(mem_rd), 32'd1);
                           check("hold5_last_addr", 32'(mem_addr), 32'h021);
        wait_stb(20);

        // Reset in HOLD with counter 5.
        @(posedge clk_50);
        #1 reset = 1'b0; run = 1'b0;
        @(posedge clk_50);
        @(negedge clk_50);
        check("hold_rst_seq", 32'(seq_num), 32'd0);
        check("hold_rst_step", 32'(step), 32'd0);
        check("hold_rst_pattern", 32'(pattern), 32'd0);
        check("hold_rst_addr", 32'(mem_addr), 32'd0);
        check("hold_rst_rd", 32'(mem_rd), 32'd0);
        @(posedge clk_50);
        #1 reset = 1'b1;
        repeat (3) begin
            @(negedge clk_50); check("paused_rd", 32'(mem_rd), 32'd0);
        end

        // Change sequence while paused, then run: fetch {1,0}.
        set_btn(1'b1, 1'b0);
        @(negedge clk_50); check("pause_seq", 32'(seq_num), 32'd1);
                           check("pause_rd", 32'(mem_rd), 32'd0);
        push_exp(10'h010);
        @(posedge clk_50);
        #1 run = 1'b1;
        wait_stb(20);
        set_btn(1'b0, 1'b0);

        // Walk all 16 steps of sequence 1 (no EOS): step 15 wraps to 0.
        for (int s = 1; s < 16; s++) begin
            push_exp(10'h010 + s);
            do_tick();
            wait_stb(20);
        end
        check("step15", 32'(step), 32'd15);
        push_exp(10'h010);
        do_tick();
        @(negedge clk_50); check("wrap15_step", 32'(step), 32'd0);
                           check("wrap15_addr", 32'(mem_addr), 32'h010);
        wait_stb(20);

        // Pause during WAIT discards the read; resume refetches the step.
        do_tick();                       // FETCH for 0x011
        @(posedge clk_50);
        #1 run = 1'b0;                   // WAIT cycle
        repeat (4) begin
            @(negedge clk_50); check("pausewait_stb", 32'(pattern_stb), 32'd0);
        end
        push_exp(10'h011);
        @(posedge clk_50);
        #1 run = 1'b1;
        wait_stb(20);

        repeat (3) @(negedge clk_50);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
